// File: rtl/control_mac_filtro.sv
// MAC sequencer for the filter: on each sample strobe it walks the taps, accumulates
// the products in a guarded accumulator, then rescales and saturates the sum into y.
module control_mac_filtro #(
  parameter int N    = 25,
  parameter int K    = 5,
  parameter int FRAC = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [2*N-1:0] producto,
  output logic [$clog2(K)-1:0]  sel,
  output logic                  busy,
  output logic signed [N-1:0]   y,
  output logic                  done,
  output logic                  overrun
);

  localparam int SW = $clog2(K);
  // Guard bits let K full-scale products add up without wrapping.
  localparam int AW = 2*N + $clog2(K);

  localparam logic signed [AW-1:0] Y_MAX = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, SAT} state_t;

  state_t               state, state_next;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] producto_ext;
  logic signed [AW-1:0] shifted;
  logic signed [N-1:0]  y_sat;
  logic                 last_tap;

  assign producto_ext = {{(AW-2*N){producto[2*N-1]}}, producto};
  assign shifted      = acc >>> FRAC;
  assign last_tap     = (sel == SW'(K-1));
  assign busy         = (state != IDLE);

  always_comb begin
    if (shifted > Y_MAX)      y_sat = Y_MAX[N-1:0];
    else if (shifted < Y_MIN) y_sat = Y_MIN[N-1:0];
    else                      y_sat = shifted[N-1:0];
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = ACCUM;
      ACCUM:   if (last_tap) state_next = SAT;
      SAT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= '0;
      acc     <= '0;
      y       <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (start && state != IDLE) overrun <= 1'b1;
      unique case (state)
        CLEAR: begin
          acc <= '0;
          sel <= '0;
        end
        ACCUM: begin
          acc <= acc + producto_ext;
          // sel returns to 0 on the last tap so it reads 0 outside ACCUM.
          sel <= last_tap ? '0 : sel + 1'b1;
        end
        SAT: begin
          y    <= y_sat;
          done <= 1'b1;
          sel  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
